// File: rtl/eeprom_read_seq_if.sv
// Command/response bus between the EEPROM read sequencer and the I2C byte controller.
interface eeprom_read_seq_if;
    logic [6:0] addr;
    logic [7:0] data_in;
    logic       enable;
    logic       rw;
    logic [7:0] data_out;
    logic       ready;
    logic       data_rdy;
    logic       write_done;

    modport master (
        output addr, data_in, enable, rw,
        input  data_out, ready, data_rdy, write_done
    );

    modport slave (
        input  addr, data_in, enable, rw,
        output data_out, ready, data_rdy, write_done
    );
endinterface

// File: rtl/eeprom_read_seq.sv
// Sequential EEPROM reader: one pointer write, then one single-byte read per byte,
// with bytes buffered in a small FIFO and streamed out on a valid/ready port.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a request; FIFO may still be draining
// WR_PTR    | dummy write of the word address to the EEPROM pointer
// WAIT_IDLE | waiting for the controller to return to ready
// RD_REQ    | waiting for a free FIFO slot before issuing a read
// RD_WAIT   | single-byte read in flight, waiting for data_rdy
// FINISH    | one-cycle done pulse (success or timeout)
module eeprom_read_seq #(
    parameter logic [6:0]  DEV_ADDR       = 7'b1010000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_word_addr,
    input  logic [7:0]          req_len,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                done,
    output logic                err,
    eeprom_read_seq_if.master   ctl
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_PTR    = 3'd1,
        S_WAIT_IDLE = 3'd2,
        S_RD_REQ    = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic             rw_q, rw_d;
    logic [7:0]       din_q, din_d;
    logic [8:0]       rem_q, rem_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Timeout is a down-counter reloaded on every state change; terminal count is zero.
    assign tmo_hit = (tmo_q == '0);

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        rw_d    = rw_q;
        din_d   = din_q;
        rem_d   = rem_q;
        err_d   = err_q;
        tmo_d   = (tmo_q != '0) ? tmo_q - 1'b1 : tmo_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    err_d = 1'b0;
                    rem_d = {1'b0, req_len};
                    if (req_len == 8'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_WR_PTR;
                        en_d    = 1'b1;
                        rw_d    = 1'b0;
                        din_d   = req_word_addr;
                    end
                end
            end
            S_WR_PTR: begin
                if (ctl.write_done) begin
                    en_d    = 1'b0;
                    state_d = S_WAIT_IDLE;
                end else if (tmo_hit) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_WAIT_IDLE: begin
                if (ctl.ready) begin
                    state_d = (rem_q != 9'd0) ? S_RD_REQ : S_FINISH;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_RD_REQ: begin
                // Only one read is ever in flight, so a free slot now is a free slot at push time.
                if (count_q < DEPTH_C) begin
                    en_d    = 1'b1;
                    rw_d    = 1'b1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (ctl.data_rdy) begin
                    rem_d   = rem_q - 9'd1;
                    en_d    = 1'b0;
                    state_d = S_WAIT_IDLE;
                end else if (tmo_hit) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            tmo_d = TMO_LOAD;
        end
    end

    assign push = (state_q == S_RD_WAIT) && ctl.data_rdy;
    assign pop  = rd_ready && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = ctl.data_out;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            rw_q     <= 1'b0;
            din_q    <= 8'd0;
            rem_q    <= 9'd0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            mem_q    <= '{default: 8'd0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            rw_q     <= rw_d;
            din_q    <= din_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign err         = err_q;
    assign rd_valid    = (count_q != '0);
    assign rd_data     = mem_q[rd_ptr_q];
    assign ctl.addr    = DEV_ADDR;
    assign ctl.data_in = din_q;
    assign ctl.enable  = en_q;
    assign ctl.rw      = rw_q;

endmodule
